// File: rtl/irq_conditioner.sv
// Interrupt line conditioner: sync, polarity, level/edge latch, optional debounce (IRQ_CONDITIONER_DEBOUNCE_EN).
// Latency: input change to w_int_src in 3 clocks (4+DEBOUNCE with debounce); register read data 1 clock after w_offset.
// Backpressure: none; register accesses complete every cycle and interrupt lines are levels.
module irq_conditioner #(
    parameter int N_SRC = 32,
    parameter int W_DB  = 8
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic [29:0]      w_offset,
    input  logic             w_we,
    input  logic [31:0]      w_wdata,
    output logic [31:0]      w_rdata,
    input  logic [N_SRC-1:0] w_irq_in,
    output logic [N_SRC-1:0] w_int_src
);

    localparam logic [29:0] OFF_MODE  = 30'h00;
    localparam logic [29:0] OFF_POL   = 30'h04;
    localparam logic [29:0] OFF_LATCH = 30'h08;
    localparam logic [29:0] OFF_RAW   = 30'h0C;
    localparam logic [29:0] OFF_DEB   = 30'h10;

    logic [N_SRC-1:0] s1, s2, filt, cond, cond_q;
    logic [N_SRC-1:0] mode_q, pol_q, latch_q;
    logic [N_SRC-1:0] mode_nxt, latch_nxt, edge_set, w1c, mode_clr, int_nxt;
    logic [W_DB-1:0]  db_q;
    logic             wr_mode, wr_pol, wr_latch;
    logic [31:0]      rd;

    assign wr_mode  = w_we && (w_offset == OFF_MODE);
    assign wr_pol   = w_we && (w_offset == OFF_POL);
    assign wr_latch = w_we && (w_offset == OFF_LATCH);

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= w_irq_in;
            s2 <= s1;
        end
    end

`ifdef IRQ_CONDITIONER_DEBOUNCE_EN
    logic [N_SRC-1:0] f_q;
    logic [W_DB-1:0]  cnt_q [N_SRC];
    logic             wr_deb;

    assign wr_deb = w_we && (w_offset == OFF_DEB);
    assign filt   = f_q;

    // A line must disagree with its filtered value for DEBOUNCE+1 straight cycles to flip it.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            db_q <= '0;
            f_q  <= '0;
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
        end else begin
            if (wr_deb) db_q <= w_wdata[W_DB-1:0];
            for (int i = 0; i < N_SRC; i++) begin
                if (s2[i] == f_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == db_q) begin
                    f_q[i]   <= s2[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + W_DB'(1);
                end
            end
        end
    end
`else
    assign filt = s2;
    assign db_q = '0;
`endif

    assign cond     = filt ^ pol_q;
    assign edge_set = mode_q & cond & ~cond_q;
    assign w1c      = wr_latch ? w_wdata[N_SRC-1:0] : '0;
    assign mode_clr = wr_mode ? (mode_q & ~w_wdata[N_SRC-1:0]) : '0;
    assign mode_nxt = wr_mode ? w_wdata[N_SRC-1:0] : mode_q;
    // A fresh edge beats a same-cycle W1C; leaving edge mode always wipes the latch.
    assign latch_nxt = ((latch_q & ~w1c) | edge_set) & ~mode_clr;
    assign int_nxt   = (mode_nxt & latch_nxt) | (~mode_nxt & cond);

    always_comb begin
        rd = '0;
        case (w_offset)
            OFF_MODE:  rd[N_SRC-1:0] = mode_q;
            OFF_POL:   rd[N_SRC-1:0] = pol_q;
            OFF_LATCH: rd[N_SRC-1:0] = latch_q;
            OFF_RAW:   rd[N_SRC-1:0] = cond;
            OFF_DEB:   rd[W_DB-1:0]  = db_q;
            default:   rd = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            mode_q    <= '0;
            pol_q     <= '0;
            latch_q   <= '0;
            cond_q    <= '0;
            w_int_src <= '0;
            w_rdata   <= '0;
        end else begin
            mode_q    <= mode_nxt;
            if (wr_pol) pol_q <= w_wdata[N_SRC-1:0];
            latch_q   <= latch_nxt;
            cond_q    <= cond;
            w_int_src <= int_nxt;
            w_rdata   <= rd;
        end
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed bench for irq_conditioner: level, edge/W1C, polarity, decode, debounce and async reset.
module tb_irq_conditioner;

`ifdef IRQ_CONDITIONER_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        CLK = 1'b0;
    logic        RST_X;
    logic [29:0] w_offset;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [31:0] w_irq_in;
    logic [31:0] w_int_src;

    int errors = 0;
    int checks = 0;
    logic [31:0] rv;

    irq_conditioner #(.N_SRC(32), .W_DB(8)) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .w_offset  (w_offset),
        .w_we      (w_we),
        .w_wdata   (w_wdata),
        .w_rdata   (w_rdata),
        .w_irq_in  (w_irq_in),
        .w_int_src (w_int_src)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [29:0] off, input logic [31:0] data);
        w_offset = off;
        w_wdata  = data;
        w_we     = 1'b1;
        tick(1);
        w_we     = 1'b0;
        w_wdata  = '0;
    endtask

    task automatic rd(input logic [29:0] off, output logic [31:0] data);
        w_offset = off;
        w_we     = 1'b0;
        tick(1);
        data = w_rdata;
    endtask

    initial begin
        RST_X    = 1'b0;
        w_offset = '0;
        w_we     = 1'b0;
        w_wdata  = '0;
        w_irq_in = '0;
        tick(3);
        chk("reset_int_src", w_int_src, 32'h0);
        chk("reset_rdata", w_rdata, 32'h0);
        RST_X = 1'b1;
        tick(1);
        chk("no_latch_after_release", w_int_src, 32'h0);
        rd(30'h00, rv); chk("reset_mode", rv, 32'h0);
        rd(30'h04, rv); chk("reset_pol", rv, 32'h0);
        rd(30'h08, rv); chk("reset_latch", rv, 32'h0);
        rd(30'h0C, rv); chk("reset_raw", rv, 32'h0);

        // Level mode, line 3
        w_irq_in[3] = 1'b1;
        tick(LAT - 1);
        chk("level_rise_early", w_int_src, 32'h0);
        tick(1);
        chk("level_rise", w_int_src, 32'h8);
        rd(30'h0C, rv); chk("level_raw", rv, 32'h8);
        w_irq_in[3] = 1'b0;
        tick(LAT - 1);
        chk("level_fall_early", w_int_src, 32'h8);
        tick(1);
        chk("level_fall", w_int_src, 32'h0);

        // Edge mode, line 5: latch holds after the pulse
        wr(30'h00, 32'h20);
        w_irq_in[5] = 1'b1;
        tick(3);
        w_irq_in[5] = 1'b0;
        tick(5);
        chk("edge_hold", w_int_src, 32'h20);
        rd(30'h08, rv); chk("edge_latch_rd", rv, 32'h20);
        wr(30'h08, 32'h0);
        chk("w1c_zero_noop", w_int_src, 32'h20);
        wr(30'h08, 32'h20);
        chk("w1c_clear_int", w_int_src, 32'h0);
        rd(30'h08, rv); chk("w1c_clear_rd", rv, 32'h0);

        // Edge and W1C on the same clock: set wins
        w_irq_in[5] = 1'b1;
        tick(LAT - 1);
        wr(30'h08, 32'h20);
        chk("set_beats_clr_int", w_int_src, 32'h20);
        rd(30'h08, rv); chk("set_beats_clr_rd", rv, 32'h20);
        w_irq_in[5] = 1'b0;
        tick(LAT + 1);
        chk("latch_holds_after_fall", w_int_src, 32'h20);
        wr(30'h00, 32'h0);
        chk("mode_exit_int", w_int_src, 32'h0);
        rd(30'h08, rv); chk("mode_exit_latch", rv, 32'h0);

        // Polarity inversion on line 0
        wr(30'h04, 32'h1);
        tick(1);
        chk("pol_int", w_int_src, 32'h1);
        rd(30'h0C, rv); chk("pol_raw", rv, 32'h1);
        rd(30'h04, rv); chk("pol_rd", rv, 32'h1);
        wr(30'h04, 32'h0);
        tick(1);
        chk("pol_off_int", w_int_src, 32'h0);

        // Decode: unmapped, RAW write ignored, full-width compare
        wr(30'h14, 32'hFFFF_FFFF);
        rd(30'h14, rv); chk("unmapped_rd", rv, 32'h0);
        wr(30'h0C, 32'hFFFF_FFFF);
        rd(30'h0C, rv); chk("raw_write_ignored", rv, 32'h0);
        wr(30'h00, 32'h0000_0003);
        rd(30'h2000_0000, rv); chk("alias_rd", rv, 32'h0);
        wr(30'h2000_0000, 32'hFFFF_FFFF);
        rd(30'h00, rv); chk("alias_write_ignored", rv, 32'h3);
        wr(30'h00, 32'h0);
        wr(30'h10, 32'h4);
        rd(30'h10, rv);
`ifdef IRQ_CONDITIONER_DEBOUNCE_EN
        chk("deb_rd", rv, 32'h4);
        // 3-cycle glitch is rejected, 10-cycle assertion passes at edge 8
        w_irq_in[2] = 1'b1;
        tick(3);
        w_irq_in[2] = 1'b0;
        tick(12);
        chk("deb_glitch", w_int_src, 32'h0);
        w_irq_in[2] = 1'b1;
        tick(7);
        chk("deb_edge7", w_int_src, 32'h0);
        tick(1);
        chk("deb_edge8", w_int_src, 32'h4);
        tick(2);
        w_irq_in[2] = 1'b0;
        tick(12);
        chk("deb_release", w_int_src, 32'h0);
`else
        chk("deb_disabled_rd", rv, 32'h0);
`endif

        // Async reset with LATCH=0xFF (polarity write creates the edges)
        wr(30'h00, 32'hFF);
        wr(30'h04, 32'hFF);
        tick(2);
        chk("pre_reset_int", w_int_src, 32'hFF);
        rd(30'h08, rv); chk("pre_reset_latch", rv, 32'hFF);
        #2;
        RST_X = 1'b0;
        #1;
        chk("async_reset_int", w_int_src, 32'h0);
        chk("async_reset_rdata", w_rdata, 32'h0);
        tick(2);
        RST_X = 1'b1;
        tick(1);
        rd(30'h00, rv); chk("post_reset_mode", rv, 32'h0);
        rd(30'h04, rv); chk("post_reset_pol", rv, 32'h0);
        rd(30'h08, rv); chk("post_reset_latch", rv, 32'h0);
        rd(30'h0C, rv); chk("post_reset_raw", rv, 32'h0);
        rd(30'h10, rv); chk("post_reset_deb", rv, 32'h0);
        chk("post_reset_int", w_int_src, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
